square_motion_ctrl: RTL and testbench

- Controller that sequences position updates for the on-screen square overlay. It owns the square's x (row) and y (column) coordinates.
- Debounces the four active-low direction buttons and applies at most one step per frame, only on a frame-start strobe, so the overlay never tears mid-scan.
- Implements press-to-move, hold-to-repeat auto-repeat, and clamping to the visible area.
- Feeds x_pos/y_pos to the pixel-overlay stage.

---
 rtl/square_motion_ctrl_pkg.sv | 49 ++++
 rtl/square_motion_ctrl_button_debounce.sv | 59 +++++
 rtl/square_motion_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_square_motion_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/square_motion_ctrl_pkg.sv
// Shared types and helpers for the square overlay motion controller.
//   state_t  : motion sequencer states
//   dir_t    : 2-bit direction code, also the button index (left=0 .. down=3)
//   COORD_W  : width of the x/y coordinate outputs
//   sat_step : one signed step of a coordinate, saturated to [0, max_pos]
package sq_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        DELAY  = 2'd2,
        REPEAT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    // One extra bit gives a sign, so an underflow below 0 is seen as negative
    // instead of wrapping to a large positive coordinate.
    function automatic logic [COORD_W-1:0] sat_step(
        input logic [COORD_W-1:0] pos,
        input logic               dec,
        input logic [COORD_W-1:0] step,
        input logic [COORD_W-1:0] max_pos
    );
        logic signed [COORD_W:0] sum;
        logic signed [COORD_W:0] hi;
        hi = $signed({1'b0, max_pos});
        if (dec) begin
            sum = $signed({1'b0, pos}) - $signed({1'b0, step});
        end else begin
            sum = $signed({1'b0, pos}) + $signed({1'b0, step});
        end
        if (sum[COORD_W] == 1'b1) begin
            return {COORD_W{1'b0}};
        end else if (sum > hi) begin
            return max_pos;
        end else begin
            return sum[COORD_W-1:0];
        end
    endfunction

endpackage

// File: rtl/square_motion_ctrl_button_debounce.sv
// Synchroniser plus stability-counter debouncer for one active-low button.
//   clk, reset : system clock, asynchronous active-high reset
//   btn_n      : raw active-low button level, asynchronous to clk
//   pressed    : debounced level, 1 = pressed; clears to released on reset
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic pressed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_d, sync1_q;
    logic             sync2_d, sync2_q;
    logic             level_d, level_q;
    logic [CNT_W-1:0] cnt_d,   cnt_q;

    // Accepted level moves only after the synchronised level has disagreed
    // with it on DEBOUNCE_CYCLES consecutive clocks; any agreement restarts.
    always_comb begin
        sync1_d = ~btn_n;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                cnt_d   = {CNT_W{1'b0}};
            end else begin
                level_d = level_q;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end else begin
            level_d = level_q;
            cnt_d   = {CNT_W{1'b0}};
        end
    end

    // Synchroniser, accepted level and stability counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed = level_q;

endmodule

// File: rtl/square_motion_ctrl.sv
// Motion controller for the on-screen square overlay. Debounces four
// active-low direction buttons and steps the square at most once per
// frame_start, with press-to-move, hold-to-repeat and clamping.
//   clk, reset              : system clock, asynchronous active-high reset
//   left, right, up, down   : raw active-low buttons
//   frame_start             : one-clk pulse at start of vertical blanking
//   x_pos, y_pos            : top-edge row / left-edge column of the square
//   move_pulse              : one-clk pulse when x_pos or y_pos changes
module square_motion_ctrl
    import sq_pkg::*;
#(
    parameter int X_INIT          = 100,
    parameter int Y_INIT          = 100,
    parameter int W               = 20,
    parameter int H               = 40,
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 15,
    parameter int REPEAT_PERIOD   = 2,
    parameter int STEP            = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               left,
    input  logic               right,
    input  logic               up,
    input  logic               down,
    input  logic               frame_start,
    output logic [COORD_W-1:0] x_pos,
    output logic [COORD_W-1:0] y_pos,
    output logic               move_pulse
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(SCREEN_H - H);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(SCREEN_W - W);
    localparam logic [COORD_W-1:0] X_RST  = COORD_W'(X_INIT);
    localparam logic [COORD_W-1:0] Y_RST  = COORD_W'(Y_INIT);
    localparam logic [COORD_W-1:0] STEP_V = COORD_W'(STEP);

    logic [3:0]         pressed;
    logic               any_pressed;
    dir_t               active_dir;
    logic [COORD_W-1:0] stepped_x, stepped_y;
    logic [CNT_W-1:0]   cnt_inc;
    logic               do_step;

    state_t             state_d, state_q;
    dir_t               dir_d,   dir_q;
    logic [CNT_W-1:0]   cnt_d,   cnt_q;
    logic [COORD_W-1:0] x_d,     x_q;
    logic [COORD_W-1:0] y_d,     y_q;
    logic               move_d,  move_q;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left  (.clk(clk), .reset(reset), .btn_n(left),  .pressed(pressed[0]));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (.clk(clk), .reset(reset), .btn_n(right), .pressed(pressed[1]));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up    (.clk(clk), .reset(reset), .btn_n(up),    .pressed(pressed[2]));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down  (.clk(clk), .reset(reset), .btn_n(down),  .pressed(pressed[3]));

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Priority pick of the active direction: left > right > up > down.
    always_comb begin
        any_pressed = |pressed;
        if (pressed[0]) begin
            active_dir = DIR_LEFT;
        end else if (pressed[1]) begin
            active_dir = DIR_RIGHT;
        end else if (pressed[2]) begin
            active_dir = DIR_UP;
        end else begin
            active_dir = DIR_DOWN;
        end
    end

    // Candidate position after one saturated step in the latched direction.
    always_comb begin
        stepped_x = x_q;
        stepped_y = y_q;
        case (dir_q)
            DIR_LEFT:  stepped_y = sat_step(y_q, 1'b1, STEP_V, Y_MAX);
            DIR_RIGHT: stepped_y = sat_step(y_q, 1'b0, STEP_V, Y_MAX);
            DIR_UP:    stepped_x = sat_step(x_q, 1'b1, STEP_V, X_MAX);
            DIR_DOWN:  stepped_x = sat_step(x_q, 1'b0, STEP_V, X_MAX);
            default: begin
                stepped_x = x_q;
                stepped_y = y_q;
            end
        endcase
    end

    // Sequencer next state: release and direction change take priority over
    // frame_start, so neither can produce a step in the cycle they happen.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        do_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_pressed) begin
                    state_d = ARM;
                    dir_d   = active_dir;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            ARM, DELAY, REPEAT: begin
                if (!any_pressed) begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (active_dir != dir_q) begin
                    state_d = ARM;
                    dir_d   = active_dir;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (frame_start) begin
                    case (state_q)
                        ARM: begin
                            do_step = 1'b1;
                            cnt_d   = {CNT_W{1'b0}};
                            state_d = DELAY;
                        end
                        DELAY: begin
                            if (cnt_inc == CNT_W'(REPEAT_DELAY)) begin
                                do_step = 1'b1;
                                cnt_d   = {CNT_W{1'b0}};
                                state_d = REPEAT;
                            end else begin
                                cnt_d   = cnt_inc;
                            end
                        end
                        REPEAT: begin
                            if (cnt_inc == CNT_W'(REPEAT_PERIOD)) begin
                                do_step = 1'b1;
                                cnt_d   = {CNT_W{1'b0}};
                            end else begin
                                cnt_d   = cnt_inc;
                            end
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Position update; a step pinned at a bound changes nothing and stays silent.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        move_d = 1'b0;
        if (do_step) begin
            x_d    = stepped_x;
            y_d    = stepped_y;
            move_d = (stepped_x != x_q) || (stepped_y != y_q);
        end else begin
            move_d = 1'b0;
        end
    end

    // State, counter and position registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= DIR_LEFT;
            cnt_q   <= {CNT_W{1'b0}};
            x_q     <= X_RST;
            y_q     <= Y_RST;
            move_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            move_q  <= move_d;
        end
    end

    assign x_pos      = x_q;
    assign y_pos      = y_q;
    assign move_pulse = move_q;

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Self-checking bench for square_motion_ctrl: a hold/frame-count reference
// model compared every cycle, plus literal expectations at key points.
module tb_square_motion_ctrl;

    localparam int DB   = 4;
    localparam int RD   = 3;
    localparam int RP   = 2;
    localparam int XMAX = 440;
    localparam int YMAX = 620;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic [3:0] press = 4'b0000;   // 1 = pressed; bit 0 left, 1 right, 2 up, 3 down
    logic       left, right, up, down;
    logic [9:0] x_pos, y_pos;
    logic       move_pulse;

    int checks = 0;
    int errors = 0;
    int frame_gap = 20;
    int frame_cnt = 0;
    int pulse_cnt = 0;

    assign left  = ~press[0];
    assign right = ~press[1];
    assign up    = ~press[2];
    assign down  = ~press[3];

    square_motion_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset),
        .left(left), .right(right), .up(up), .down(down),
        .frame_start(frame_start),
        .x_pos(x_pos), .y_pos(y_pos), .move_pulse(move_pulse)
    );

    always #5 clk = ~clk;

    // Frame strobe generator with adjustable spacing.
    initial begin
        forever begin
            repeat (frame_gap - 1) @(negedge clk);
            frame_start = 1'b1;
            frame_cnt++;
            @(negedge clk);
            frame_start = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    int       m_x, m_y;
    bit       m_move;
    bit [3:0] m_s1, m_s2, m_deb;
    int       m_run [4];
    int       m_hold, m_n;

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // A hold counts eligible frames; steps fall on frame 1, 1+RD, 1+RD+RP, ...
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_x = 100; m_y = 100; m_move = 1'b0;
            m_s1 = 4'b0; m_s2 = 4'b0; m_deb = 4'b0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_hold = -1; m_n = 0;
        end else begin
            int act, nx, ny;
            act = -1;
            for (int i = 3; i >= 0; i--) if (m_deb[i]) act = i;
            m_move = 1'b0;
            if (act < 0) begin
                m_hold = -1; m_n = 0;
            end else if (act != m_hold) begin
                m_hold = act; m_n = 0;
            end else if (frame_start) begin
                m_n++;
                if (m_n == 1 || (m_n >= 1 + RD && (m_n - 1 - RD) % RP == 0)) begin
                    nx = m_x; ny = m_y;
                    case (act)
                        0: ny = ny - 1;
                        1: ny = ny + 1;
                        2: nx = nx - 1;
                        default: nx = nx + 1;
                    endcase
                    nx = clampi(nx, XMAX);
                    ny = clampi(ny, YMAX);
                    m_move = (nx != m_x) || (ny != m_y);
                    m_x = nx; m_y = ny;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_deb[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = press;
        end
    end

    // Per-cycle comparison against the model, plus move_pulse counting.
    always @(negedge clk) begin
        checks++;
        if ($isunknown({x_pos, y_pos, move_pulse}) || int'(x_pos) != m_x ||
            int'(y_pos) != m_y || move_pulse != m_move) begin
            errors++;
            $display("FAIL model_cmp t=%0t x=%0d exp %0d y=%0d exp %0d move=%0b exp %0b",
                     $time, x_pos, m_x, y_pos, m_y, move_pulse, m_move);
        end
        if (move_pulse === 1'b1) pulse_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_frames(input int n);
        int tgt, budget;
        tgt = frame_cnt + n;
        budget = 0;
        while (frame_cnt < tgt && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        if (frame_cnt < tgt) check("wait_frames_timeout", frame_cnt, tgt);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_pos(input bit is_x, input int target);
        int budget;
        budget = 0;
        while ((is_x ? m_x : m_y) != target && budget < 40000) begin
            @(negedge clk);
            budget++;
        end
        if ((is_x ? m_x : m_y) != target) check("wait_pos_timeout", is_x ? m_x : m_y, target);
    endtask

    int p0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_x", int'(x_pos), 100);
        check("reset_y", int'(y_pos), 100);
        check("reset_move", int'(move_pulse), 0);
        reset = 1'b0;
        wait_frames(10);
        check("idle_x", int'(x_pos), 100);
        check("idle_y", int'(y_pos), 100);
        check("idle_pulses", pulse_cnt, 0);

        // Glitch shorter than the debounce window
        press[1] = 1'b1;
        repeat (2) @(negedge clk);
        press[1] = 1'b0;
        wait_frames(2);
        check("glitch_y", int'(y_pos), 100);
        check("glitch_pulses", pulse_cnt, 0);

        // Right held 8 frames: steps on frames 1, 4, 6, 8
        wait_frames(1);
        p0 = pulse_cnt;
        press[1] = 1'b1;
        wait_frames(8);
        check("hold_right_y", int'(y_pos), 104);
        check("hold_right_pulses", pulse_cnt - p0, 4);
        press = 4'b0000;
        wait_frames(2);

        // Left and up together: left wins; then release left -> up re-arms
        press = 4'b0101;
        wait_frames(6);
        check("left_up_y", int'(y_pos), 101);
        check("left_up_x", int'(x_pos), 100);
        press = 4'b0100;
        wait_frames(1);
        check("rearm_up_x", int'(x_pos), 99);
        check("rearm_up_y", int'(y_pos), 101);
        press = 4'b0000;
        wait_frames(2);

        // Right clamp at 620
        frame_gap = 8;
        press[1] = 1'b1;
        wait_pos(1'b0, 619);
        press = 4'b0000;
        wait_frames(3);
        frame_gap = 20;
        wait_frames(1);
        check("pre_clamp_y", int'(y_pos), 619);
        p0 = pulse_cnt;
        press[1] = 1'b1;
        wait_frames(5);
        check("clamp_right_y", int'(y_pos), 620);
        check("clamp_right_pulses", pulse_cnt - p0, 1);
        press = 4'b0000;
        wait_frames(2);

        // Down clamp at 440
        frame_gap = 8;
        press[3] = 1'b1;
        wait_pos(1'b1, 439);
        press = 4'b0000;
        wait_frames(3);
        frame_gap = 20;
        wait_frames(1);
        check("pre_clamp_x_hi", int'(x_pos), 439);
        p0 = pulse_cnt;
        press[3] = 1'b1;
        wait_frames(5);
        check("clamp_down_x", int'(x_pos), 440);
        check("clamp_down_pulses", pulse_cnt - p0, 1);
        press = 4'b0000;
        wait_frames(2);

        // Up clamp at 0
        frame_gap = 8;
        press[2] = 1'b1;
        wait_pos(1'b1, 1);
        press = 4'b0000;
        wait_frames(3);
        frame_gap = 20;
        wait_frames(1);
        check("pre_clamp_x_lo", int'(x_pos), 1);
        p0 = pulse_cnt;
        press[2] = 1'b1;
        wait_frames(5);
        check("clamp_up_x", int'(x_pos), 0);
        check("clamp_up_pulses", pulse_cnt - p0, 1);
        press = 4'b0000;
        wait_frames(2);

        // Reset in the middle of auto-repeat, button kept held
        press[0] = 1'b1;
        wait_frames(8);
        check("repeat_left_y", int'(y_pos), 616);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_x", int'(x_pos), 100);
        check("midreset_y", int'(y_pos), 100);
        check("midreset_move", int'(move_pulse), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        p0 = pulse_cnt;
        repeat (5) @(negedge clk);
        check("post_reset_no_early_step", pulse_cnt - p0, 0);
        wait_frames(2);
        check("post_reset_y", int'(y_pos), 99);
        check("post_reset_x", int'(x_pos), 100);
        press = 4'b0000;
        wait_frames(2);

        // Randomised button patterns and frame spacing
        for (int s = 0; s < 60; s++) begin
            frame_gap = $urandom_range(24, 6);
            if ($urandom_range(3, 0) == 0) press = 4'b0000;
            else press = 4'($urandom_range(15, 0));
            repeat ($urandom_range(80, 1)) @(negedge clk);
        end
        press = 4'b0000;
        frame_gap = 20;
        wait_frames(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
